// File: rtl/alarm_bank_if.sv
// alarm_bank_if: bundles the alarm-setting UI and ringer status signals.
//   cur_time              packed {year,month,day,hour,minute,second}
//   wr_en/wr_idx/wr_time/wr_mode   slot programming
//   ack/snooze            user controls for the current ring
//   ringing/ring_idx/snoozing/armed/pending   status back to buzzer/LCD logic
// master = UI/status side, slave = alarm_bank.
interface alarm_bank_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
);
  logic [47:0]           cur_time;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [47:0]           wr_time;
  logic [1:0]            wr_mode;
  logic                  ack;
  logic                  snooze;
  logic                  ringing;
  logic [IDX_W-1:0]      ring_idx;
  logic                  snoozing;
  logic [NUM_ALARMS-1:0] armed;
  logic [NUM_ALARMS-1:0] pending;

  modport master (
    output cur_time, wr_en, wr_idx, wr_time, wr_mode, ack, snooze,
    input  ringing, ring_idx, snoozing, armed, pending
  );

  modport slave (
    input  cur_time, wr_en, wr_idx, wr_time, wr_mode, ack, snooze,
    output ringing, ring_idx, snoozing, armed, pending
  );
endinterface

// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS programmable alarm slots (one-shot or daily) compared
// every second against the watch time, arbitrated onto one ringer with
// dismiss, user snooze and auto-snooze after RING_SEC seconds of ringing.
// Ports:
//   clk1sec  1 Hz clock, all state on rising edge
//   rst      asynchronous active-low reset
//   bus      alarm_bank_if.slave (slot writes, ack/snooze, ringer status)
// wr_mode: 00 off, 01 once (full 48-bit match), 10 daily (low 24 bits), 11 off.
module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk1sec,
  input  logic       rst,
  alarm_bank_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t                state;
  logic [47:0]           slot_time [NUM_ALARMS];
  logic [1:0]            slot_mode [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] armed;
  logic [NUM_ALARMS-1:0] match;
  logic [NUM_ALARMS-1:0] wr_hit;
  logic [NUM_ALARMS-1:0] eligible;
  logic [NUM_ALARMS-1:0] pending_q;
  logic [NUM_ALARMS-1:0] pend_next;
  logic                  launch_vld;
  logic [IDX_W-1:0]      launch_idx;
  logic [IDX_W-1:0]      ring_idx_q;
  logic                  ringing_q;
  logic                  snoozing_q;
  logic                  active_wr;
  logic [7:0]            ring_cnt;
  logic [2:0]            snz_cnt;
  logic [15:0]           countdown;

  // Per-slot decode: armed state, time match and write select.
  // Out-of-range wr_idx selects no slot, so such writes are dropped.
  always_comb begin
    armed  = '0;
    match  = '0;
    wr_hit = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      armed[i]  = (slot_mode[i] == 2'b01) || (slot_mode[i] == 2'b10);
      wr_hit[i] = bus.wr_en && (32'(bus.wr_idx) == i);
      if (slot_mode[i] == 2'b01)
        match[i] = (bus.cur_time == slot_time[i]);
      else if (slot_mode[i] == 2'b10)
        match[i] = (bus.cur_time[23:0] == slot_time[i][23:0]);
    end
  end

  // Lowest pending slot not being rewritten this edge gets the ringer.
  always_comb begin
    eligible   = pending_q & ~wr_hit;
    launch_vld = |eligible;
    launch_idx = '0;
    for (int unsigned i = NUM_ALARMS; i > 0; i--) begin
      if (eligible[i-1])
        launch_idx = IDX_W'(i-1);
    end
  end

  // A write to the slot currently owning the ringer cancels it.
  always_comb begin
    active_wr = (state != IDLE) && wr_hit[ring_idx_q];
  end

  // Launch consumes the old pending bit first, so a daily slot re-matching on
  // its own launch edge stays pending; writes override any fresh match.
  always_comb begin
    pend_next = pending_q;
    if (state == IDLE && launch_vld)
      pend_next[launch_idx] = 1'b0;
    pend_next = (pend_next | match) & ~wr_hit;
  end

  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        slot_time[i] <= '0;
        slot_mode[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (wr_hit[i]) begin
          slot_time[i] <= bus.wr_time;
          slot_mode[i] <= bus.wr_mode;
        end else if (match[i] && slot_mode[i] == 2'b01) begin
          slot_mode[i] <= 2'b00;
        end
      end
    end
  end

  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pending_q  <= '0;
      ring_idx_q <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      countdown  <= '0;
    end else begin
      pending_q <= pend_next;
      case (state)
        IDLE: begin
          if (launch_vld) begin
            state      <= RING;
            ring_idx_q <= launch_idx;
            ringing_q  <= 1'b1;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
          end
        end
        RING: begin
          if (active_wr || bus.ack) begin
            state     <= IDLE;
            ringing_q <= 1'b0;
          end else if (bus.snooze) begin
            state      <= SNOOZE;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b1;
            countdown  <= 16'(SNOOZE_SEC);
          end else if (ring_cnt == 8'(RING_SEC - 1)) begin
            ringing_q <= 1'b0;
            if (snz_cnt < 3'(MAX_SNOOZE)) begin
              state      <= SNOOZE;
              snoozing_q <= 1'b1;
              snz_cnt    <= snz_cnt + 3'd1;
              countdown  <= 16'(SNOOZE_SEC);
            end else begin
              state <= IDLE;
            end
          end else begin
            ring_cnt <= ring_cnt + 8'd1;
          end
        end
        SNOOZE: begin
          if (active_wr || bus.ack) begin
            state      <= IDLE;
            snoozing_q <= 1'b0;
          end else if (countdown == 16'd1) begin
            state      <= RING;
            ringing_q  <= 1'b1;
            snoozing_q <= 1'b0;
            ring_cnt   <= '0;
          end else begin
            countdown <= countdown - 16'd1;
          end
        end
        default: begin
          state      <= IDLE;
          ringing_q  <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ringing  = ringing_q;
  assign bus.snoozing = snoozing_q;
  assign bus.ring_idx = ring_idx_q;
  assign bus.pending  = pending_q;
  assign bus.armed    = armed;

endmodule

// File: tb/tb_alarm_bank.sv
module tb_alarm_bank;
  localparam int NA  = 4;
  localparam int IW  = 2;
  localparam int SNZ = 2;
  localparam int RS  = 3;
  localparam int MS  = 1;
  localparam logic [47:0] QUIET = 48'h01_01_01_17_59_59;

  logic clk1sec = 1'b0;
  logic rst     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk1sec = ~clk1sec;

  alarm_bank_if #(.NUM_ALARMS(NA), .IDX_W(IW)) bif ();

  alarm_bank #(
    .NUM_ALARMS(NA), .IDX_W(IW), .SNOOZE_SEC(SNZ), .RING_SEC(RS), .MAX_SNOOZE(MS)
  ) dut (
    .clk1sec(clk1sec),
    .rst    (rst),
    .bus    (bif.slave)
  );

  // Reference model: slot table plus a ringer described by seconds remaining.
  logic [47:0] m_time [NA];
  logic [1:0]  m_mode [NA];
  bit          m_pend [NA];
  bit          m_ring, m_snz;
  int          m_idx, m_ring_left, m_snz_left, m_auto;

  function automatic void model_reset();
    for (int i = 0; i < NA; i++) begin
      m_time[i] = '0; m_mode[i] = 2'b00; m_pend[i] = 1'b0;
    end
    m_ring = 0; m_snz = 0; m_idx = 0; m_ring_left = 0; m_snz_left = 0; m_auto = 0;
  endfunction

  function automatic void model_step();
    bit hit [NA];
    bit wr  [NA];
    for (int i = 0; i < NA; i++) begin
      wr[i] = bif.wr_en && (int'(bif.wr_idx) == i);
      case (m_mode[i])
        2'b01:   hit[i] = (bif.cur_time == m_time[i]);
        2'b10:   hit[i] = (bif.cur_time[23:0] == m_time[i][23:0]);
        default: hit[i] = 1'b0;
      endcase
    end
    if (m_ring) begin
      if (wr[m_idx] || bif.ack) m_ring = 0;
      else if (bif.snooze) begin m_ring = 0; m_snz = 1; m_snz_left = SNZ; end
      else if (m_ring_left == 1) begin
        m_ring = 0;
        if (m_auto < MS) begin m_auto++; m_snz = 1; m_snz_left = SNZ; end
      end else m_ring_left--;
    end else if (m_snz) begin
      if (wr[m_idx] || bif.ack) m_snz = 0;
      else if (m_snz_left == 1) begin m_snz = 0; m_ring = 1; m_ring_left = RS; end
      else m_snz_left--;
    end else begin
      for (int i = 0; i < NA; i++) begin
        if (m_pend[i] && !wr[i]) begin
          m_ring = 1; m_idx = i; m_ring_left = RS; m_auto = 0; m_pend[i] = 0;
          break;
        end
      end
    end
    for (int i = 0; i < NA; i++) begin
      if (hit[i]) m_pend[i] = 1'b1;
      if (wr[i]) begin
        m_pend[i] = 1'b0;
        m_time[i] = bif.wr_time;
        m_mode[i] = bif.wr_mode;
      end else if (hit[i] && m_mode[i] == 2'b01) begin
        m_mode[i] = 2'b00;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NA-1:0] ea, ep;
    for (int i = 0; i < NA; i++) begin
      ea[i] = (m_mode[i] == 2'b01) || (m_mode[i] == 2'b10);
      ep[i] = m_pend[i];
    end
    chk({tag, "_ringing"},  64'(bif.ringing),  64'(m_ring));
    chk({tag, "_snoozing"}, 64'(bif.snoozing), 64'(m_snz));
    chk({tag, "_armed"},    64'(bif.armed),    64'(ea));
    chk({tag, "_pending"},  64'(bif.pending),  64'(ep));
    if (m_ring || m_snz)
      chk({tag, "_ring_idx"}, 64'(bif.ring_idx), 64'(m_idx));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk1sec);
    #1;
    check_all(tag);
  endtask

  task automatic quiet();
    bif.wr_en = 1'b0; bif.ack = 1'b0; bif.snooze = 1'b0;
    bif.cur_time = QUIET; bif.wr_idx = '0; bif.wr_time = '0; bif.wr_mode = 2'b00;
  endtask

  task automatic write_slot(input int idx, input logic [47:0] t, input logic [1:0] m,
                            input string tag);
    quiet();
    bif.wr_en = 1'b1; bif.wr_idx = IW'(idx); bif.wr_time = t; bif.wr_mode = m;
    tick(tag);
    quiet();
  endtask

  logic [9:0] pat;

  initial begin
    quiet();
    model_reset();
    #1 rst = 1'b0;
    #2;
    check_all("reset");
    chk("reset_ring_idx", 64'(bif.ring_idx), 64'd0);
    #9 rst = 1'b1;

    // One-shot slot 0: pending on the match edge, ringing one edge later.
    write_slot(0, 48'h19_0C_0F_07_00_00, 2'b01, "s0_wr");
    bif.cur_time = 48'h19_0C_0F_07_00_00;
    tick("s0_match");
    chk("s0_pend_bit",  64'(bif.pending[0]), 64'd1);
    chk("s0_disarmed",  64'(bif.armed[0]),   64'd0);
    quiet();
    tick("s0_launch");
    chk("s0_ringing", 64'(bif.ringing), 64'd1);
    bif.ack = 1'b1; tick("s0_ack"); quiet();

    // Daily slot 1 on two dates.
    write_slot(1, 48'h00_00_00_07_1E_00, 2'b10, "s1_wr");
    for (int d = 0; d < 2; d++) begin
      bif.cur_time = {8'h19, 8'h0C, 8'(15 + d), 24'h07_1E_00};
      tick("s1_match"); quiet();
      tick("s1_launch");
      chk("s1_ringing", 64'(bif.ringing), 64'd1);
      chk("s1_armed",   64'(bif.armed[1]), 64'd1);
      bif.ack = 1'b1; tick("s1_ack"); quiet();
    end

    // Slots 2 and 3 firing together: lowest index first.
    write_slot(2, 48'h19_0C_10_09_00_00, 2'b01, "s23_wr2");
    write_slot(3, 48'h19_0C_10_09_00_00, 2'b01, "s23_wr3");
    bif.cur_time = 48'h19_0C_10_09_00_00;
    tick("s23_match"); quiet();
    tick("s23_first");
    chk("s23_idx2", 64'(bif.ring_idx), 64'd2);
    bif.ack = 1'b1; tick("s23_ack"); quiet();
    tick("s23_second");
    chk("s23_idx3", 64'(bif.ring_idx), 64'd3);
    bif.ack = 1'b1; tick("s23_ack2"); quiet();

    // Unattended ring: 3 s ring, 2 s snooze, 3 s ring, forced dismiss.
    bif.cur_time = 48'h19_0C_11_07_1E_00;
    tick("as_match"); quiet();
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      tick("as_run");
      pat = {pat[8:0], bif.ringing};
    end
    chk("as_pattern", 64'(pat), 64'(10'b1110011100));

    // Randomized traffic around a small pool of dates/times.
    for (int n = 0; n < 400; n++) begin
      quiet();
      bif.cur_time = {8'h19, 8'h0C, 8'($urandom_range(1, 3)),
                      8'h07, 8'($urandom_range(0, 1) * 30), 8'h00};
      if ($urandom_range(0, 99) < 8) begin
        bif.wr_en   = 1'b1;
        bif.wr_idx  = IW'($urandom_range(0, NA - 1));
        bif.wr_mode = 2'($urandom_range(0, 3));
        bif.wr_time = {8'h19, 8'h0C, 8'($urandom_range(1, 3)),
                       8'h07, 8'($urandom_range(0, 1) * 30), 8'h00};
      end
      bif.ack    = ($urandom_range(0, 99) < 10);
      bif.snooze = ($urandom_range(0, 99) < 10);
      tick("rand");
    end

    // Turn every slot off; this also clears pending and cancels the ringer.
    for (int i = 0; i < NA; i++) write_slot(i, '0, 2'b00, "clr");
    tick("clr_idle");

    // ack and snooze together: dismiss wins.
    write_slot(3, 48'h19_0C_12_08_00_00, 2'b01, "as_wr");
    bif.cur_time = 48'h19_0C_12_08_00_00;
    tick("ak_match"); quiet();
    tick("ak_launch");
    bif.ack = 1'b1; bif.snooze = 1'b1;
    tick("ak_both");
    chk("ak_ringing",  64'(bif.ringing),  64'd0);
    chk("ak_snoozing", 64'(bif.snoozing), 64'd0);
    quiet();

    // Rewriting the ringing slot silences it on the next edge.
    write_slot(2, 48'h19_0C_12_09_00_00, 2'b01, "wr_set");
    bif.cur_time = 48'h19_0C_12_09_00_00;
    tick("wr_match"); quiet();
    tick("wr_launch");
    write_slot(2, 48'h19_0C_12_09_00_00, 2'b01, "wr_ring");
    chk("wr_silenced", 64'(bif.ringing), 64'd0);

    // Asynchronous reset while snoozing.
    write_slot(1, 48'h00_00_00_07_1E_00, 2'b10, "rs_wr");
    bif.cur_time = 48'h19_0C_13_07_1E_00;
    tick("rs_match"); quiet();
    tick("rs_launch");
    bif.snooze = 1'b1; tick("rs_snooze"); quiet();
    chk("rs_in_snooze", 64'(bif.snoozing), 64'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("rs_async");
    chk("rs_armed_zero", 64'(bif.armed), 64'd0);
    #2 rst = 1'b1;
    tick("rs_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
